gf2m_poly_mult_seq: RTL and testbench
=====================================

Name: gf2m_poly_mult_seq

Overview:
- Sequential carry-less (GF(2)[z]) polynomial multiplier.
- Produces the unreduced product p(z) = a(z)·b(z) of two field elements. This is the 2W-bit operand that the existing combinational GF(2^4) reduction block consumes to reduce modulo f(z).
- Sits upstream of the reduction stage in the ECC datapath. Uses a shift-and-XOR loop with a valid/ready handshake on both sides.

Parameters:
- W, 4, operand width in bits (field degree m); product width is 2W.

Ports:
- clk  input  1  system clock, rising edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  W  multiplicand polynomial, bit i = coefficient of z^i
- b  input  W  multiplier polynomial, bit i = coefficient of z^i
- out_valid  output  1  product p valid, held until accepted
- out_ready  input  1  downstream accepts p
- p  output  2W  unreduced product; p[2W-1] is always 0 (max degree 2W-2)
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, p=0.
  - Internal a_reg, b_reg, acc and cnt cleared.
  - Reset asserted mid-operation aborts it; no partial result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On a clk edge with in_valid=1: latch a_reg=a, b_reg=b, acc=0, cnt=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (W cycles):
  - Each edge: acc <= (acc<<1) ^ (b_reg[W-1] ? {W'b0, a_reg} : 0); b_reg <<= 1; cnt <= cnt+1.
  - This processes the multiplier MSB-first.
  - On the edge where cnt==W-1 (the W-th step): p <= final acc value, out_valid <= 1; go to DONE.
  - a and b are ignored during RUN; in_ready=0.
- DONE:
  - p and out_valid are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid <= 0; go to IDLE.
  - in_valid is ignored in DONE, so there is no same-cycle re-accept and one idle bubble between operations.
- Latency:
  - Operands accepted at edge k give out_valid=1 after edge k+W (W=4 → 4 cycles).
  - Throughput is one product per W+2 cycles with out_ready tied high.
- Arithmetic:
  - Pure XOR accumulation; no carries.
  - acc is 2W bits wide. Shifting can never carry out past bit 2W-2, so p[2W-1]=0 always.
- p is registered; it changes only on the edge entering DONE and on reset. It keeps its last value in IDLE/RUN.
- Boundaries:
  - a=0 or b=0 gives p=0, with the full W-cycle latency (no early exit).
  - in_valid held high continuously: exactly one operand pair is accepted per IDLE visit.
  - out_ready high before out_valid has no effect.
  - cnt wraps only through the state change; it is cleared on accept.

Test Plan:
- Reset then a=4'b0101, b=4'b0110, in_valid pulse → out_valid exactly 4 cycles after accept, p=8'h1E (z^4+z^3+z^2+z); in_ready low during RUN/DONE.
- a=4'b1111, b=4'b1111 → p=8'h55. Then a=4'b1001, b=4'b1011 → p=8'h53. Then a=4'b0001, b=4'b1010 → p=8'h0A (identity). Confirm p[7]=0 in every case.
- a=4'b0000, b=4'b1101 → p=8'h00 after the full 4-cycle latency.
- Backpressure: out_ready low for 5 cycles after out_valid; toggle a, b and in_valid throughout → p stays 8'h1E, out_valid stays high, no new accept. Raise out_ready → out_valid drops next edge, in_ready=1.
- Reset mid-RUN (rst_n low, asynchronously, 2 cycles after accept) → immediately out_valid=0, p=0, in_ready=1. A following operation a=4'b0011, b=4'b0011 → p=8'h05.
- in_valid and out_ready tied high, 3 back-to-back operations → each accepted every 6 cycles, results in order.

Source files
------------

// File: rtl/gf2m_poly_mult_seq_if.sv
// Operand/product handshake bundle for the sequential GF(2)[z] multiplier.
// master drives operands and the output accept; slave is the multiplier.
interface gf2m_poly_mult_seq_if #(parameter int W = 4);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, p, busy);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, p, busy);
endinterface

// File: rtl/gf2m_poly_mult_seq.sv
// Shift-and-XOR carry-less multiplier: the unreduced 2W-bit product a(z)*b(z),
// built MSB-first over W cycles, feeding the downstream mod-f(z) reduction.
module gf2m_poly_mult_seq #(
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  gf2m_poly_mult_seq_if.slave bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] p_q, p_d;
  logic           out_valid_q, out_valid_d;
  logic [2*W-1:0] acc_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    // Horner step: shift the partial product up one degree, then add a(z)
    // if the current multiplier coefficient is set.
    acc_step = {acc_q[2*W-2:0], 1'b0} ^ (b_q[W-1] ? {{W{1'b0}}, a_q} : '0);
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_step;
        b_d   = {b_q[W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          p_d         = acc_step;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // No re-accept here: the next operand waits for one IDLE cycle.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
endmodule

// File: tb/tb_gf2m_poly_mult_seq.sv
// Scoreboard bench for gf2m_poly_mult_seq: accepts push a reference product,
// an independent monitor pops and checks value, latency and hold behaviour.
module tb_gf2m_poly_mult_seq;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gf2m_poly_mult_seq_if #(.W(W)) bus();

  gf2m_poly_mult_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [2*W-1:0] p;
    int             acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int b2b = 0;
  int last_acc = -1;
  logic prev_ov = 1'b0;
  logic prev_hs = 1'b0;
  logic [2*W-1:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: schoolbook product over GF(2), coefficient by coefficient.
  function automatic logic [2*W-1:0] clmul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (x[i] && y[j]) r[i+j] = ~r[i+j];
    return r;
  endfunction

  // Monitor: sample mid-cycle; an accept seen here happens on the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back('{clmul(bus.a, bus.b), cyc + 1});
        if (b2b != 0 && last_acc >= 0) chk("b2b_interval", cyc + 1 - last_acc, 6);
        last_acc = cyc + 1;
      end
      if (prev_hs) chk("ov_drop_after_accept", bus.out_valid, 0);
      if (bus.out_valid && !prev_ov) begin
        if (sb.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = sb.pop_front();
          chk("product", bus.p, e.p);
          chk("latency", cyc, e.acc_cyc + W);
          chk("p_msb_zero", bus.p[2*W-1], 0);
        end
        held = bus.p;
      end else if (bus.out_valid && prev_ov) begin
        chk("p_hold", bus.p, held);
      end
      if (bus.busy) chk("in_ready_low_busy", bus.in_ready, 0);
      prev_ov = bus.out_valid;
      prev_hs = bus.out_valid && bus.out_ready;
    end else begin
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end
  end

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!bus.in_ready && n < bound) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) chk("timeout_idle", 0, 1);
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    wait_idle(40);
    bus.a = x; bus.b = y; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_p"}, bus.p, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Backpressure on the first result; operands and in_valid wiggle meanwhile.
    bus.out_ready = 1'b0;
    issue(4'b0101, 4'b0110);
    chk("in_ready_run", bus.in_ready, 0);
    for (int n = 0; n < 10 && !bus.out_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("ov_seen", bus.out_valid, 1);
    for (int n = 0; n < 5; n++) begin
      bus.a = W'($urandom); bus.b = W'($urandom); bus.in_valid = 1'($urandom);
      @(posedge clk); #1;
      chk("bp_ov_held", bus.out_valid, 1);
      chk("bp_p_1e", bus.p, 8'h1E);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_ov", bus.out_valid, 0);
    chk("release_in_ready", bus.in_ready, 1);

    // Directed products, out_ready already high.
    issue(4'b1111, 4'b1111);
    issue(4'b1001, 4'b1011);
    issue(4'b0001, 4'b1010);
    issue(4'b0000, 4'b1101);
    wait_idle(40);
    chk("directed_ff", clmul(4'b1111, 4'b1111), 8'h55);

    // Asynchronous reset two cycles into RUN aborts the operation.
    issue(4'b0101, 4'b0110);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrun_reset");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(4'b0011, 4'b0011);
    wait_idle(40);
    chk("after_reset_p", bus.p, 8'h05);

    // Back-to-back with in_valid and out_ready held high.
    wait_idle(40);
    last_acc = -1;
    b2b = 1;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 17; n++) begin
      bus.a = W'($urandom); bus.b = W'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_idle(40);
    b2b = 0;

    // Random operands with random backpressure.
    for (int k = 0; k < 20; k++) begin
      issue(W'($urandom), W'($urandom));
      for (int n = 0; n < 60 && !bus.in_ready; n++) begin
        bus.out_ready = 1'($urandom);
        @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
    end
    wait_idle(40);

    repeat (8) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
